// File: rtl/motion_pkg.sv
// Shared types and widths for the motion profile sequencer and its tick prescaler.
package motion_pkg;

  localparam int TIME_W   = 64;
  localparam int PARAM_W  = 32;
  localparam int N_TIMING = 4;
  localparam int N_PARAMS = 5;

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_ACC    = 3'd1,
    PH_CRUISE = 3'd2,
    PH_DEC    = 3'd3,
    PH_TAIL   = 3'd4
  } phase_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  // A zero-length phase has equal start and end times, so its test never
  // matches and the lookup falls through to the next phase.
  function automatic phase_t phase_of(input logic [TIME_W-1:0] e,
                                      input logic [TIME_W-1:0] t0,
                                      input logic [TIME_W-1:0] t1,
                                      input logic [TIME_W-1:0] t2);
    if (e < t0)      return PH_ACC;
    else if (e < t1) return PH_CRUISE;
    else if (e < t2) return PH_DEC;
    else             return PH_TAIL;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into timing ticks: one-cycle strobe every PRESCALE enabled cycles.
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] count;

  assign tick = enable && (count == CW'(PRESCALE - 1));

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (enable)    count <= tick ? '0 : count + CW'(1);
  end

endmodule

// File: rtl/motion_profile_sequencer.sv
// Requests a max-timing calculation, latches the winning profile and plays it out
// tick by tick, reporting the current motion phase and the move outcome.
module motion_profile_sequencer
  import motion_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int TIMEOUT  = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               move_req,
  input  logic               abort,
  output logic               calc_start,
  input  logic               calc_finish,
  input  logic [TIME_W-1:0]  timing_in  [0:N_TIMING-1],
  input  logic [PARAM_W-1:0] params_in  [0:N_PARAMS-1],
  output logic [PARAM_W-1:0] params_out [0:N_PARAMS-1],
  output logic [2:0]         phase,
  output logic [TIME_W-1:0]  elapsed,
  output logic               tick,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               aborted
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_t        state;
  phase_t            phase_q;
  logic [TIME_W-1:0] timing_q [0:N_TIMING-1];
  logic [WAIT_W-1:0] wait_cnt;
  logic [TIME_W-1:0] elapsed_nxt;
  logic              run_tick;
  logic              monotonic;
  logic              abortable;

  assign abortable   = (state == ST_REQ) || (state == ST_CHECK) || (state == ST_RUN);
  assign elapsed_nxt = elapsed + TIME_W'(1);
  assign monotonic   = (timing_q[0] <= timing_q[1]) && (timing_q[1] <= timing_q[2]) &&
                       (timing_q[2] <= timing_q[3]);

  // An abort on the same cycle as the final tick must not advance elapsed.
  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable ((state == ST_RUN) && !abort),
    .clear  (state != ST_RUN),
    .tick   (run_tick)
  );

  // NOTE: timing_q is pure data storage, only read after a latch in REQ, so it
  // carries no reset and stays a plain register bank.
  always_ff @(posedge clk) begin
    if ((state == ST_REQ) && calc_finish && !abort) timing_q <= timing_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase_q    <= PH_IDLE;
      calc_start <= 1'b0;
      elapsed    <= '0;
      wait_cnt   <= '0;
      err        <= 1'b0;
      aborted    <= 1'b0;
      params_out <= '{default: '0};
    end else if (abortable && abort) begin
      aborted    <= 1'b1;
      calc_start <= 1'b0;
      phase_q    <= PH_IDLE;
      state      <= ST_DONE;
    end else begin
      case (state)
        ST_IDLE: if (move_req) begin
          state      <= ST_REQ;
          calc_start <= 1'b1;
          err        <= 1'b0;
          aborted    <= 1'b0;
          elapsed    <= '0;
          wait_cnt   <= '0;
        end
        ST_REQ: if (calc_finish) begin
          params_out <= params_in;
          calc_start <= 1'b0;
          state      <= ST_CHECK;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          err        <= 1'b1;
          calc_start <= 1'b0;
          state      <= ST_DONE;
        end else begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        ST_CHECK: if (!monotonic) begin
          err   <= 1'b1;
          state <= ST_DONE;
        end else if (timing_q[3] == '0) begin
          state <= ST_DONE;
        end else begin
          elapsed <= '0;
          phase_q <= phase_of('0, timing_q[0], timing_q[1], timing_q[2]);
          state   <= ST_RUN;
        end
        ST_RUN: if (run_tick) begin
          elapsed <= elapsed_nxt;
          if (elapsed_nxt == timing_q[3]) begin
            phase_q <= PH_IDLE;
            state   <= ST_DONE;
          end else begin
            phase_q <= phase_of(elapsed_nxt, timing_q[0], timing_q[1], timing_q[2]);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign phase = phase_q;
  assign tick  = run_tick;
  assign ready = (state == ST_IDLE);
  assign busy  = abortable;
  assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_motion_profile_sequencer.sv
// Scoreboard bench: each move pushes its expected outcome; a monitor tallies phases,
// ticks and calc_start cycles and compares them when done is presented.
module tb_motion_profile_sequencer;
  import motion_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic move_req_a = 1'b0, move_req_b = 1'b0, abort = 1'b0, calc_finish = 1'b0;
  logic sel = 1'b0;
  logic [63:0] timing_in [0:3];
  logic [31:0] params_in [0:4];

  logic cs_a, tick_a, ready_a, busy_a, done_a, err_a, ab_a;
  logic cs_b, tick_b, ready_b, busy_b, done_b, err_b, ab_b;
  logic [2:0] ph_a, ph_b;
  logic [63:0] el_a, el_b;
  logic [31:0] po_a [0:4];
  logic [31:0] po_b [0:4];

  motion_profile_sequencer #(.PRESCALE(1), .TIMEOUT(16)) dut_a (
    .clk(clk), .reset(reset), .move_req(move_req_a), .abort(abort),
    .calc_start(cs_a), .calc_finish(calc_finish), .timing_in(timing_in),
    .params_in(params_in), .params_out(po_a), .phase(ph_a), .elapsed(el_a),
    .tick(tick_a), .ready(ready_a), .busy(busy_a), .done(done_a), .err(err_a),
    .aborted(ab_a)
  );

  motion_profile_sequencer #(.PRESCALE(4), .TIMEOUT(16)) dut_b (
    .clk(clk), .reset(reset), .move_req(move_req_b), .abort(abort),
    .calc_start(cs_b), .calc_finish(calc_finish), .timing_in(timing_in),
    .params_in(params_in), .params_out(po_b), .phase(ph_b), .elapsed(el_b),
    .tick(tick_b), .ready(ready_b), .busy(busy_b), .done(done_b), .err(err_b),
    .aborted(ab_b)
  );

  logic m_cs, m_tick, m_done, m_err, m_ab;
  logic [2:0] m_ph;
  logic [63:0] m_el;
  assign m_cs   = sel ? cs_b   : cs_a;
  assign m_tick = sel ? tick_b : tick_a;
  assign m_done = sel ? done_b : done_a;
  assign m_err  = sel ? err_b  : err_a;
  assign m_ab   = sel ? ab_b   : ab_a;
  assign m_ph   = sel ? ph_b   : ph_a;
  assign m_el   = sel ? el_b   : el_a;

  typedef struct packed {
    logic            err;
    logic            aborted;
    logic [63:0]     elapsed;
    int              acc;
    int              cru;
    int              dec;
    int              tail;
    int              ticks;
    int              first_tick;
    int              cs;
    logic [4:0][31:0] prm;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  int acc_n, cru_n, dec_n, tail_n, tick_n, first_n, run_n, cs_n;

  task automatic clear_counts();
    acc_n = 0; cru_n = 0; dec_n = 0; tail_n = 0;
    tick_n = 0; first_n = 999; run_n = 0; cs_n = 0;
  endtask

  initial clear_counts();

  always @(negedge clk) begin
    if (reset) begin
      clear_counts();
    end else begin
      if (m_cs) cs_n++;
      case (m_ph)
        3'd1: acc_n++;
        3'd2: cru_n++;
        3'd3: dec_n++;
        3'd4: tail_n++;
        default: ;
      endcase
      if (m_tick) begin
        if (tick_n == 0) first_n = run_n;
        tick_n++;
      end
      if (m_ph != 3'd0) run_n++;
      if (m_done) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("err", m_err, e.err);
          check("aborted", m_ab, e.aborted);
          check("elapsed", m_el, e.elapsed);
          check("acc_cycles", acc_n, e.acc);
          check("cruise_cycles", cru_n, e.cru);
          check("dec_cycles", dec_n, e.dec);
          check("tail_cycles", tail_n, e.tail);
          check("tick_count", tick_n, e.ticks);
          check("first_tick_cycle", first_n, e.first_tick);
          check("calc_start_cycles", cs_n, e.cs);
          check("calc_start_at_done", m_cs, 0);
          for (int i = 0; i < 5; i++)
            check($sformatf("params_out[%0d]", i), sel ? po_b[i] : po_a[i], e.prm[i]);
        end
        clear_counts();
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_timing(input logic [63:0] t0, t1, t2, t3);
    timing_in[0] = t0; timing_in[1] = t1; timing_in[2] = t2; timing_in[3] = t3;
  endtask

  task automatic set_params(input int base);
    for (int i = 0; i < 5; i++) params_in[i] = 32'(base + i);
  endtask

  task automatic push_exp(input logic e_err, e_ab, input logic [63:0] el,
                          input int acc, cru, dec, tail, ticks, first, cs, base);
    exp_t e;
    e.err = e_err; e.aborted = e_ab; e.elapsed = el;
    e.acc = acc; e.cru = cru; e.dec = dec; e.tail = tail;
    e.ticks = ticks; e.first_tick = first; e.cs = cs;
    for (int i = 0; i < 5; i++) e.prm[i] = 32'(base + i);
    sb_q.push_back(e);
  endtask

  task automatic start_move();
    cyc(1);
    if (sel) move_req_b = 1'b1; else move_req_a = 1'b1;
    cyc(1);
    move_req_a = 1'b0;
    move_req_b = 1'b0;
  endtask

  task automatic finish_after(input int n);
    repeat (n) @(posedge clk);
    #1 calc_finish = 1'b1;
    cyc(1);
    calc_finish = 1'b0;
  endtask

  task automatic wait_ready(input int limit);
    for (int i = 0; i < limit; i++) begin
      cyc(1);
      if ((sel ? ready_b : ready_a) == 1'b1) return;
    end
    checks++;
    failures++;
    $display("FAIL wait_ready_timeout actual=0 required=1");
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    set_timing(0, 0, 0, 0);
    set_params(0);
    cyc(3);
    check("rst_ready_a", ready_a, 1);
    check("rst_ready_b", ready_b, 1);
    check("rst_calc_start", cs_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err_aborted", {err_a, ab_a}, 0);
    check("rst_phase", ph_a, 0);
    check("rst_elapsed", el_a, 0);
    check("rst_tick", tick_b, 0);
    check("rst_params_out", po_a[0], 0);
    reset = 1'b0;
    cyc(2);

    // PRESCALE=1 full profile; stray calc_finish and move_req during RUN are ignored
    sel = 1'b0;
    set_timing(10, 20, 30, 30);
    set_params(100);
    push_exp(0, 0, 30, 10, 10, 10, 0, 30, 0, 4, 100);
    start_move();
    finish_after(3);
    cyc(5);
    set_params(900);
    calc_finish = 1'b1;
    move_req_a = 1'b1;
    cyc(1);
    calc_finish = 1'b0;
    move_req_a = 1'b0;
    wait_ready(100);

    // Non-monotonic timing
    set_timing(10, 5, 30, 30);
    set_params(200);
    push_exp(1, 0, 0, 0, 0, 0, 0, 0, 999, 1, 200);
    start_move();
    finish_after(0);
    wait_ready(20);
    check("err_sticky", err_a, 1);

    // Abort at elapsed 7
    set_timing(10, 20, 30, 30);
    set_params(300);
    push_exp(0, 1, 7, 8, 0, 0, 0, 7, 0, 2, 300);
    start_move();
    check("err_cleared_by_move_req", err_a, 0);
    finish_after(1);
    begin : wait_el7
      for (int i = 0; i < 100; i++) begin
        if (el_a == 64'd7) disable wait_el7;
        cyc(1);
      end
      check("wait_elapsed7_timeout", 0, 1);
    end
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    wait_ready(20);
    check("aborted_sticky", ab_a, 1);

    // All-zero timing: straight to DONE after CHECK
    set_timing(0, 0, 0, 0);
    set_params(400);
    push_exp(0, 0, 0, 0, 0, 0, 0, 0, 999, 1, 400);
    start_move();
    check("aborted_cleared_by_move_req", ab_a, 0);
    finish_after(0);
    wait_ready(20);

    // PRESCALE=4: skipped ACC and DEC, TAIL present
    sel = 1'b1;
    set_timing(0, 8, 8, 12);
    set_params(500);
    push_exp(0, 0, 12, 0, 32, 0, 16, 12, 3, 2, 500);
    start_move();
    finish_after(1);
    cyc(10);
    move_req_b = 1'b1;
    cyc(1);
    move_req_b = 1'b0;
    wait_ready(200);

    // Timeout with calc_finish held low; params_out keeps the previous latch
    set_params(600);
    push_exp(1, 0, 0, 0, 0, 0, 0, 0, 999, 16, 500);
    start_move();
    wait_ready(40);

    // Reset during REQ and during RUN
    set_timing(0, 8, 8, 12);
    start_move();
    check("req_calc_start", cs_b, 1);
    reset = 1'b1;
    cyc(1);
    check("rst_req_calc_start", cs_b, 0);
    reset = 1'b0;
    start_move();
    finish_after(0);
    begin : wait_tick
      for (int i = 0; i < 50; i++) begin
        if (tick_b) disable wait_tick;
        cyc(1);
      end
      check("wait_tick_timeout", 0, 1);
    end
    reset = 1'b1;
    cyc(1);
    check("rst_run_ready", ready_b, 1);
    check("rst_run_calc_start", cs_b, 0);
    check("rst_run_busy", busy_b, 0);
    check("rst_run_elapsed", el_b, 0);
    check("rst_run_phase", ph_b, 0);
    check("rst_run_params_out", po_b[0], 0);
    reset = 1'b0;
    cyc(3);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
